// File: rtl/ahb_ctrl_pkg.sv
// Shared types and address map for the USB endpoint AHB-Lite slave controller.
// Holds decoder state codes, FSM states, size codes and the buffer-readiness helper.
package ahb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10,
    ST_ERROR = 2'b11
  } dec_state_e;

  typedef enum logic [2:0] {
    F_IDLE = 3'd0,
    F_WAIT = 3'd1,
    F_DATA = 3'd2,
    F_ERR1 = 3'd3,
    F_ERR2 = 3'd4
  } fsm_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  localparam logic [6:0] BUF_LAST    = 7'h3F;
  localparam logic [6:0] STATUS      = 7'h40;
  localparam logic [6:0] STATUS_LAST = 7'h43;
  localparam logic [6:0] ERROR_REG   = 7'h42;
  localparam logic [6:0] BO          = 7'h44;
  localparam logic [6:0] EHTS        = 7'h48;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Writes need free space (occ + n <= depth); reads need n bytes held.
  function automatic logic buf_ready(input logic       wr,
                                     input logic       is_buf,
                                     input logic [2:0] n,
                                     input logic [6:0] occ,
                                     input logic [7:0] depth);
    logic [7:0] occ8;
    logic [7:0] n8;
    occ8 = {1'b0, occ};
    n8   = {5'b0, n};
    if (!is_buf)
      return 1'b1;
    else if (wr)
      return (occ8 + n8) <= depth;
    else
      return occ8 >= n8;
  endfunction

endpackage

// File: rtl/ahb_slave_controller_if.sv
// AHB-Lite bus signals between a master and the endpoint slave controller.
// Handshake: an address phase is accepted when hsel & htrans[1] & hready at a rising clk edge.
interface ahb_slave_controller_if;
  logic       hsel;
  logic [1:0] htrans;
  logic       hwrite;
  logic [6:0] haddr;
  logic [1:0] hsize;
  logic       hready;
  logic       hresp;

  modport slave (
    input  hsel, htrans, hwrite, haddr, hsize,
    output hready, hresp
  );

  modport master (
    output hsel, htrans, hwrite, haddr, hsize,
    input  hready, hresp
  );
endinterface

// File: rtl/ahb_access_checker.sv
// Combinational legality check of an AHB address phase against the endpoint map.
// Reports illegal, whether the target is the data buffer, and the byte count.
module ahb_access_checker (
  input  logic [6:0] haddr,
  input  logic [1:0] hsize,
  input  logic       hwrite,
  output logic       illegal,
  output logic       is_buffer,
  output logic [2:0] n_bytes
);
  import ahb_ctrl_pkg::*;

  logic misaligned;
  logic unmapped;
  logic bad_write;
  logic bad_word;
  logic bad_wide;

  always_comb begin
    misaligned = ((hsize == SZ_HALF) && haddr[0]) ||
                 ((hsize == SZ_WORD) && (haddr[1:0] != 2'b00));
    unmapped   = ((haddr > BO) && (haddr < EHTS)) || (haddr > EHTS);
    // Status/error/BO registers are read-only.
    bad_write  = hwrite && (haddr >= STATUS) && (haddr <= BO);
    bad_word   = (hsize == SZ_WORD) && (haddr >= STATUS) && (haddr <= STATUS_LAST);
    bad_wide   = (hsize != SZ_BYTE) && ((haddr == BO) || (haddr == EHTS));
    illegal    = (hsize == SZ_BAD) || misaligned || unmapped ||
                 bad_write || bad_word || bad_wide;
    is_buffer  = haddr <= BUF_LAST;
    n_bytes    = size_bytes(hsize);
  end

endmodule

// File: rtl/ahb_slave_controller.sv
// AHB-Lite data-phase sequencer for the USB endpoint register/buffer map.
// Optional wait-state timeout enabled by defining AHB_CTRL_TIMEOUT_EN.
module ahb_slave_controller #(
  parameter int BUF_DEPTH = 64,
  parameter int WAIT_MAX  = 16
) (
  input  logic                        clk,
  input  logic                        nRst,
  ahb_slave_controller_if.slave       bus,
  input  logic [6:0]                  buf_occupancy,
  output logic [1:0]                  state,
  output logic                        get_rx_data,
  output logic                        store_tx_data,
  output logic [2:0]                  xfer_bytes,
  output logic [2:0]                  fsm_dbg
);
  import ahb_ctrl_pkg::*;

  localparam logic [7:0] DEPTH8 = 8'(BUF_DEPTH);

  fsm_e       fsm;
  logic       wr_q;
  logic       is_buf_q;
  logic [2:0] n_q;

  logic       illegal;
  logic       is_buffer;
  logic [2:0] n_bytes;
  logic       accept;
  logic       sel_wr;
  logic       sel_buf;
  logic [2:0] sel_n;
  logic       sel_ready;
  logic       go_data;
  logic       unused_htrans0;

  assign unused_htrans0 = bus.htrans[0];

  ahb_access_checker u_checker (
    .haddr     (bus.haddr),
    .hsize     (bus.hsize),
    .hwrite    (bus.hwrite),
    .illegal   (illegal),
    .is_buffer (is_buffer),
    .n_bytes   (n_bytes)
  );

  assign accept  = bus.hsel && bus.htrans[1] && bus.hready;
  assign fsm_dbg = fsm;

  // Moore decode of the bus response and decoder state.
  always_comb begin
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    state      = ST_IDLE;
    case (fsm)
      F_WAIT: bus.hready = 1'b0;
      F_DATA: state = wr_q ? ST_WRITE : ST_READ;
      F_ERR1: begin
        bus.hready = 1'b0;
        bus.hresp  = 1'b1;
        state      = ST_ERROR;
      end
      F_ERR2: begin
        bus.hresp = 1'b1;
        state     = ST_ERROR;
      end
      default: ;
    endcase
  end

  // In WAIT the held transfer is re-checked; elsewhere the live address phase is.
  always_comb begin
    if (fsm == F_WAIT) begin
      sel_wr  = wr_q;
      sel_buf = is_buf_q;
      sel_n   = n_q;
    end else begin
      sel_wr  = bus.hwrite;
      sel_buf = is_buffer;
      sel_n   = n_bytes;
    end
    sel_ready = buf_ready(sel_wr, sel_buf, sel_n, buf_occupancy, DEPTH8);
    go_data   = (fsm == F_WAIT) ? sel_ready : (accept && !illegal && sel_ready);
  end

`ifdef AHB_CTRL_TIMEOUT_EN
  localparam int WCW = $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);
  logic [WCW-1:0] wait_cnt;
  logic           timeout;
  assign timeout = (wait_cnt == WAIT_LAST);
`else
  localparam int UNUSED_WAIT_MAX = WAIT_MAX;
`endif

  always_ff @(posedge clk) begin
    if (!nRst) begin
      fsm           <= F_IDLE;
      wr_q          <= 1'b0;
      is_buf_q      <= 1'b0;
      n_q           <= 3'd0;
      get_rx_data   <= 1'b0;
      store_tx_data <= 1'b0;
      xfer_bytes    <= 3'd0;
`ifdef AHB_CTRL_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      // Strobes pulse only in the single DATA cycle; xfer_bytes reports n there.
      get_rx_data   <= go_data && sel_buf && !sel_wr;
      store_tx_data <= go_data && sel_buf && sel_wr;
      xfer_bytes    <= go_data ? sel_n : 3'd0;

      case (fsm)
        F_IDLE, F_DATA, F_ERR2: begin
          if (accept) begin
            wr_q     <= bus.hwrite;
            is_buf_q <= is_buffer;
            n_q      <= n_bytes;
            if (illegal)
              fsm <= F_ERR1;
            else if (sel_ready)
              fsm <= F_DATA;
            else
              fsm <= F_WAIT;
          end else begin
            fsm <= F_IDLE;
          end
        end
        F_WAIT: begin
          if (sel_ready)
            fsm <= F_DATA;
`ifdef AHB_CTRL_TIMEOUT_EN
          else if (timeout)
            fsm <= F_ERR1;
`endif
        end
        F_ERR1:  fsm <= F_ERR2;
        default: fsm <= F_IDLE;
      endcase

`ifdef AHB_CTRL_TIMEOUT_EN
      if ((fsm == F_WAIT) && !sel_ready && !timeout)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
`endif
    end
  end

endmodule
